speed_bar_ctrl: RTL and testbench
=================================

Name: speed_bar_ctrl

Overview:
Frame-rate sequencer for the speed-bar overlay. It accepts a target bar width from the test-pattern control logic. Once per N video frames it steps the bar width toward that target, and pulses the animate strobe for the rectangle generator on every width change. It also enforces a minimum dwell at the target before it accepts a new one.

Parameters:
MAX_WIDTH, 200, upper clamp on bar width in pixels (≤255)
INIT_WIDTH, 0, width after reset (≤MAX_WIDTH)
STEP, 2, pixels moved per update tick (1..MAX_WIDTH)
FRAME_DIV, 1, frames per update tick (1..255)
HOLD_FRAMES, 30, frames of dwell at target before returning to IDLE (1..4095)

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  synchronous reset, active low
i_frame  in  1  one-cycle pulse per frame (end of active video)
i_enable  in  1  sequencing enable
i_target  in  8  requested width in pixels
i_target_valid  in  1  target request
o_target_ready  out  1  target can be accepted
o_width  out  8  current bar width to the rectangle generator
o_animate  out  1  one-cycle strobe when o_width changes
o_at_target  out  1  o_width equals the accepted target
o_state  out  2  FSM state: 0 IDLE, 1 UP, 2 DOWN, 3 HOLD

Behaviour:
- Reset (i_rst_n low at an i_clk edge) applies these values:
  - state=IDLE, o_width=INIT_WIDTH, target register=INIT_WIDTH.
  - frame divider=0, hold counter=0.
  - o_animate=0, o_at_target=1.
  - Reset mid-ramp abandons the ramp with no further animate pulse.
- Update tick: internal 1-cycle signal, true when i_frame=1 and the divider equals FRAME_DIV-1.
  - The divider advances on each i_frame, wraps to 0 on tick, and runs in every state while i_enable=1.
  - With FRAME_DIV=1, every i_frame is a tick.
- Handshake:
  - o_target_ready = (state==IDLE) and i_enable. It is a combinational function of registered state only.
  - Accept = i_target_valid & o_target_ready.
  - On accept, the target register loads min(i_target, MAX_WIDTH). The clamp is an unsigned compare.
  - Next state after accept:
    - clamped target > o_width → UP
    - clamped target < o_width → DOWN
    - equal → HOLD, with the hold counter loaded to 0.
  - A tick in the same cycle as an accept is consumed without moving the width. Movement starts on the next tick.
- UP, on tick:
  - o_width ← o_width + min(STEP, target−o_width), using 9-bit intermediate arithmetic with no wrap.
  - o_animate=1 in the same cycle that o_width takes its new value (one cycle after the tick edge).
  - If the new width equals target: go to HOLD, hold counter=0.
- DOWN: mirror of UP, o_width ← o_width − min(STEP, o_width−target). It never underflows below 0.
- HOLD:
  - The hold counter increments on each i_frame (not each tick).
  - When the counter reaches HOLD_FRAMES-1 on an i_frame: go to IDLE.
- o_at_target = (o_width == target register), registered alongside o_width. It is 0 throughout UP/DOWN and 1 in HOLD and in IDLE after completion.
- o_animate: at most one pulse per tick. It is never asserted when the width is unchanged.
- i_enable=0:
  - Next cycle: state→IDLE, divider and hold counter clear.
  - o_width, target register and o_at_target are frozen. o_at_target is recomputed on later moves.
  - o_target_ready=0 and no o_animate.
  - Re-enable resumes in IDLE. Any partial ramp must be re-requested.
- Back-to-back ticks: FRAME_DIV=1 with i_frame every frame gives one step per frame. There is no minimum spacing requirement beyond 2 clocks between i_frame pulses.

Decomposition:
- Shared package (video_ctrl_pkg): state encoding constants (ST_IDLE=0, ST_UP=1, ST_DOWN=2, ST_HOLD=3) and a width typedef (8-bit pixel width). Future bar/meter controllers reuse both.
- One sub-module: frame_tick_div. It holds the parameterised i_frame divider with clear input and tick output, and is reusable by other animation sequencers.
- The FSM, step arithmetic and hold counter stay in speed_bar_ctrl.

Test Plan:
- Reset with INIT_WIDTH=0 → o_width=0, o_state=0, o_at_target=1. Then i_enable=1 → o_target_ready=1.
- Ramp up (STEP=2, FRAME_DIV=1): accept target 10 → widths 2,4,6,8,10 on 5 successive frames, each with one o_animate pulse. Then state=HOLD, o_at_target=1. After 30 i_frame pulses → IDLE, ready=1.
- Clamp and partial step: from 0 with STEP=7, request 255 with MAX_WIDTH=200 → target 200; the last step is 200−196=4. Then from 200 request 3 → DOWN, ends at exactly 3 with no underflow.
- Divider: FRAME_DIV=3, target 4 from 0 → width changes only on frames 3 and 6. A tick coincident with accept is ignored.
- Equal target: request 10 while at 10 → direct to HOLD, no o_animate.
- Disable mid-ramp: request 20 from 0, drop i_enable after width=6 → width frozen at 6, ready=0, no pulses. Re-enable → IDLE, request 20 → resumes 8,10,…
- Mid-ramp reset (rst_n low one cycle at width=8) → width=0, IDLE, and no o_animate afterwards.

Source files
------------

// File: rtl/video_ctrl_pkg.sv
// Shared types for the video overlay controllers: pixel width and the
// sequencer state encoding reused by bar/meter animation blocks.
package video_ctrl_pkg;

    typedef logic [7:0] width_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Unsigned clamp of a requested width to the controller's ceiling.
    function automatic width_t clamp_width(input width_t w, input width_t max_w);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Divides the per-frame pulse down to one update tick every FRAME_DIV frames.
module frame_tick_div #(
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_frame,
    output logic o_tick
);

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    logic [7:0] cnt;

    assign o_tick = i_frame & ~i_clr & (cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt <= '0;
        end else if (i_frame) begin
            cnt <= o_tick ? '0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/speed_bar_ctrl.sv
// Speed-bar width sequencer: steps the bar toward an accepted target once per
// update tick, strobes animate on every change, then dwells before re-arming.
module speed_bar_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WIDTH   = 200,
    parameter int unsigned INIT_WIDTH  = 0,
    parameter int unsigned STEP        = 2,
    parameter int unsigned FRAME_DIV   = 1,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame,
    input  logic       i_enable,
    input  logic [7:0] i_target,
    input  logic       i_target_valid,
    output logic       o_target_ready,
    output logic [7:0] o_width,
    output logic       o_animate,
    output logic       o_at_target,
    output logic [1:0] o_state
);

    localparam width_t     MAX_W     = width_t'(MAX_WIDTH);
    localparam width_t     INIT_W    = width_t'(INIT_WIDTH);
    localparam logic [8:0] STEP9     = 9'(STEP);
    localparam logic [11:0] HOLD_LAST = 12'(HOLD_FRAMES - 1);

    state_t      state, state_n;
    width_t      width, width_n;
    width_t      tgt, tgt_n;
    logic [11:0] hold, hold_n;
    logic        anim, anim_n;
    logic        at_tgt, at_tgt_n;
    logic        tick;

    width_t      req_clamped;
    logic [8:0]  up_diff, dn_diff, up_amt, dn_amt;
    width_t      width_up, width_dn;

    frame_tick_div #(
        .FRAME_DIV (FRAME_DIV)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~i_enable),
        .i_frame (i_frame),
        .o_tick  (tick)
    );

    // Steps are limited to the remaining distance, so neither direction can
    // overshoot the target or wrap through 0/255.
    assign req_clamped = clamp_width(i_target, MAX_W);
    assign up_diff     = {1'b0, tgt} - {1'b0, width};
    assign dn_diff     = {1'b0, width} - {1'b0, tgt};
    assign up_amt      = (up_diff < STEP9) ? up_diff : STEP9;
    assign dn_amt      = (dn_diff < STEP9) ? dn_diff : STEP9;
    assign width_up    = width + up_amt[7:0];
    assign width_dn    = width - dn_amt[7:0];

    assign o_target_ready = (state == ST_IDLE) & i_enable;
    assign o_width        = width;
    assign o_animate      = anim;
    assign o_at_target    = at_tgt;
    assign o_state        = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            width  <= INIT_W;
            tgt    <= INIT_W;
            hold   <= '0;
            anim   <= 1'b0;
            at_tgt <= 1'b1;
        end else begin
            state  <= state_n;
            width  <= width_n;
            tgt    <= tgt_n;
            hold   <= hold_n;
            anim   <= anim_n;
            at_tgt <= at_tgt_n;
        end
    end

    always_comb begin
        state_n = state;
        width_n = width;
        tgt_n   = tgt;
        hold_n  = hold;
        anim_n  = 1'b0;

        if (!i_enable) begin
            state_n = ST_IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_target_valid) begin
                        tgt_n = req_clamped;
                        if (req_clamped > width) begin
                            state_n = ST_UP;
                        end else if (req_clamped < width) begin
                            state_n = ST_DOWN;
                        end else begin
                            state_n = ST_HOLD;
                            hold_n  = '0;
                        end
                    end
                end
                ST_UP: begin
                    if (tick) begin
                        width_n = width_up;
                        anim_n  = 1'b1;
                        if (width_up == tgt) begin
                            state_n = ST_HOLD;
                            hold_n  = '0;
                        end
                    end
                end
                ST_DOWN: begin
                    if (tick) begin
                        width_n = width_dn;
                        anim_n  = 1'b1;
                        if (width_dn == tgt) begin
                            state_n = ST_HOLD;
                            hold_n  = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_frame) begin
                        if (hold == HOLD_LAST) begin
                            state_n = ST_IDLE;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold + 12'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        at_tgt_n = (width_n == tgt_n);
    end

endmodule

// File: tb/tb_speed_bar_ctrl.sv
// Directed bench for speed_bar_ctrl: three parameterisations share one
// stimulus stream; each scenario checks the instance it targets.
module tb_speed_bar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] target = '0;
    logic       valid = 1'b0;

    logic       rdy0, rdy1, rdy2;
    logic [7:0] w0, w1, w2;
    logic       an0, an1, an2;
    logic       at0, at1, at2;
    logic [1:0] st0, st1, st2;

    int checks = 0;
    int errors = 0;
    int anim0 = 0;
    int anim1 = 0;
    int anim2 = 0;

    always #5 clk = ~clk;

    speed_bar_ctrl u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame(frame), .i_enable(enable),
        .i_target(target), .i_target_valid(valid), .o_target_ready(rdy0),
        .o_width(w0), .o_animate(an0), .o_at_target(at0), .o_state(st0)
    );

    speed_bar_ctrl #(.STEP(7)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame(frame), .i_enable(enable),
        .i_target(target), .i_target_valid(valid), .o_target_ready(rdy1),
        .o_width(w1), .o_animate(an1), .o_at_target(at1), .o_state(st1)
    );

    speed_bar_ctrl #(.FRAME_DIV(3), .HOLD_FRAMES(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame(frame), .i_enable(enable),
        .i_target(target), .i_target_valid(valid), .o_target_ready(rdy2),
        .o_width(w2), .o_animate(an2), .o_at_target(at2), .o_state(st2)
    );

    // Animate pulses counted at the clock edge that ends them.
    always @(posedge clk) begin
        if (an0 === 1'b1) anim0 <= anim0 + 1;
        if (an1 === 1'b1) anim1 <= anim1 + 1;
        if (an2 === 1'b1) anim2 <= anim2 + 1;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        frame  = 1'b0;
        valid  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pulse();
            @(negedge clk);
        end
    endtask

    task automatic request(input logic [7:0] t);
        target = t;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (w0 !== 8'd0) begin errors++; $display("FAIL reset_width got %0d expected 0", w0); end
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", st0); end
        checks++; if (at0 !== 1'b1) begin errors++; $display("FAIL reset_at_target got %0b expected 1", at0); end
        checks++; if (an0 !== 1'b0) begin errors++; $display("FAIL reset_animate got %0b expected 0", an0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL ready_disabled got %0b expected 0", rdy0); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ready_enabled got %0b expected 1", rdy0); end
    endtask

    task automatic test_ramp_up();
        int a0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        a0 = anim0;
        request(8'd10);
        checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL ramp_state_up got %0d expected 1", st0); end
        checks++; if (at0 !== 1'b0) begin errors++; $display("FAIL ramp_at_target got %0b expected 0", at0); end
        for (int k = 1; k <= 5; k++) begin
            frame_pulse();
            checks++; if (w0 !== 8'(2 * k)) begin errors++; $display("FAIL ramp_width step %0d got %0d expected %0d", k, w0, 2 * k); end
            checks++; if (an0 !== 1'b1) begin errors++; $display("FAIL ramp_animate step %0d got %0b expected 1", k, an0); end
            @(negedge clk);
            checks++; if (an0 !== 1'b0) begin errors++; $display("FAIL ramp_animate_width step %0d got %0b expected 0", k, an0); end
        end
        checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL ramp_hold_state got %0d expected 3", st0); end
        checks++; if (at0 !== 1'b1) begin errors++; $display("FAIL ramp_hold_at got %0b expected 1", at0); end
        checks++; if (anim0 - a0 !== 5) begin errors++; $display("FAIL ramp_pulse_count got %0d expected 5", anim0 - a0); end
        frames(29);
        checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL hold_29 got %0d expected 3", st0); end
        frames(1);
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL hold_30 got %0d expected 0", st0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL hold_ready got %0b expected 1", rdy0); end
        // equal-target request goes straight to HOLD with no pulse
        a0 = anim0;
        request(8'd10);
        checks++; if (st0 !== 2'd3) begin errors++; $display("FAIL equal_state got %0d expected 3", st0); end
        frames(2);
        checks++; if (anim0 - a0 !== 0) begin errors++; $display("FAIL equal_no_animate got %0d expected 0", anim0 - a0); end
        checks++; if (w0 !== 8'd10 || at0 !== 1'b1) begin errors++; $display("FAIL equal_width got %0d/%0b expected 10/1", w0, at0); end
    endtask

    task automatic test_clamp();
        int a1;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        a1 = anim1;
        request(8'd255);
        checks++; if (st1 !== 2'd1) begin errors++; $display("FAIL clamp_state got %0d expected 1", st1); end
        frames(28);
        checks++; if (w1 !== 8'd196) begin errors++; $display("FAIL clamp_pre_last got %0d expected 196", w1); end
        frames(1);
        checks++; if (w1 !== 8'd200) begin errors++; $display("FAIL clamp_final got %0d expected 200", w1); end
        checks++; if (st1 !== 2'd3) begin errors++; $display("FAIL clamp_hold got %0d expected 3", st1); end
        checks++; if (anim1 - a1 !== 29) begin errors++; $display("FAIL clamp_pulses got %0d expected 29", anim1 - a1); end
        frames(30);
        checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL clamp_idle got %0d expected 0", st1); end
        request(8'd3);
        checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL down_state got %0d expected 2", st1); end
        frames(28);
        checks++; if (w1 !== 8'd4) begin errors++; $display("FAIL down_pre_last got %0d expected 4", w1); end
        frames(1);
        checks++; if (w1 !== 8'd3) begin errors++; $display("FAIL down_final got %0d expected 3", w1); end
        checks++; if (st1 !== 2'd3 || at1 !== 1'b1) begin errors++; $display("FAIL down_hold got %0d/%0b expected 3/1", st1, at1); end
        frames(2);
        checks++; if (w1 !== 8'd3) begin errors++; $display("FAIL down_stays got %0d expected 3", w1); end
    endtask

    task automatic test_divider();
        logic [7:0] exp_w [1:6] = '{8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd4};
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        request(8'd4);
        for (int k = 1; k <= 6; k++) begin
            frame_pulse();
            checks++; if (w2 !== exp_w[k]) begin errors++; $display("FAIL div_width frame %0d got %0d expected %0d", k, w2, exp_w[k]); end
            checks++; if (an2 !== (k % 3 == 0)) begin errors++; $display("FAIL div_animate frame %0d got %0b", k, an2); end
            @(negedge clk);
        end
        frames(2);
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL div_hold_idle got %0d expected 0", st2); end
        // divider now sits at 2: this accept coincides with a tick
        target = 8'd0;
        valid  = 1'b1;
        frame  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        frame  = 1'b0;
        checks++; if (st2 !== 2'd2 || w2 !== 8'd4 || an2 !== 1'b0) begin errors++; $display("FAIL div_accept_tick got st=%0d w=%0d an=%0b expected 2/4/0", st2, w2, an2); end
        @(negedge clk);
        frames(2);
        checks++; if (w2 !== 8'd4) begin errors++; $display("FAIL div_no_move got %0d expected 4", w2); end
        frames(1);
        checks++; if (w2 !== 8'd2) begin errors++; $display("FAIL div_move got %0d expected 2", w2); end
    endtask

    task automatic test_disable();
        int a0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        request(8'd20);
        frames(3);
        checks++; if (w0 !== 8'd6) begin errors++; $display("FAIL dis_pre got %0d expected 6", w0); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (st0 !== 2'd0 || rdy0 !== 1'b0) begin errors++; $display("FAIL dis_state got %0d/%0b expected 0/0", st0, rdy0); end
        a0 = anim0;
        frames(3);
        checks++; if (w0 !== 8'd6 || at0 !== 1'b0) begin errors++; $display("FAIL dis_frozen got %0d/%0b expected 6/0", w0, at0); end
        checks++; if (anim0 - a0 !== 0) begin errors++; $display("FAIL dis_no_pulse got %0d expected 0", anim0 - a0); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (st0 !== 2'd0 || rdy0 !== 1'b1) begin errors++; $display("FAIL reen_state got %0d/%0b expected 0/1", st0, rdy0); end
        request(8'd20);
        checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL reen_up got %0d expected 1", st0); end
        frames(1);
        checks++; if (w0 !== 8'd8) begin errors++; $display("FAIL reen_w8 got %0d expected 8", w0); end
        frames(1);
        checks++; if (w0 !== 8'd10) begin errors++; $display("FAIL reen_w10 got %0d expected 10", w0); end
    endtask

    task automatic test_reset_midramp();
        int a0;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        request(8'd20);
        frames(4);
        checks++; if (w0 !== 8'd8) begin errors++; $display("FAIL mrst_pre got %0d expected 8", w0); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (w0 !== 8'd0 || st0 !== 2'd0 || at0 !== 1'b1 || an0 !== 1'b0) begin errors++; $display("FAIL mrst_state got w=%0d st=%0d at=%0b an=%0b expected 0/0/1/0", w0, st0, at0, an0); end
        @(negedge clk);
        a0 = anim0;
        frames(3);
        checks++; if (anim0 - a0 !== 0 || w0 !== 8'd0) begin errors++; $display("FAIL mrst_quiet got pulses=%0d w=%0d expected 0/0", anim0 - a0, w0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_clamp();
        test_divider();
        test_disable();
        test_reset_midramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
